// File: rtl/nn_pipe_arbiter.sv
// nn_pipe_arbiter: round-robin issue of two requesters into a pipeline, with results
// steered back to their originator in issue order through a tag FIFO.
module nn_pipe_arbiter #(
    parameter int DATA_W    = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0_valid,
    input  logic [DATA_W-1:0]            req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [DATA_W-1:0]            req1_data,
    output logic                         req1_ready,
    output logic                         acc_valid,
    output logic [DATA_W-1:0]            acc_data,
    input  logic                         acc_ready,
    input  logic                         res_valid,
    input  logic [DATA_W-1:0]            res_data,
    output logic                         res_ready,
    output logic                         out0_valid,
    output logic [DATA_W-1:0]            out0_data,
    input  logic                         out0_ready,
    output logic                         out1_valid,
    output logic [DATA_W-1:0]            out1_data,
    input  logic                         out1_ready,
    output logic [$clog2(TAG_DEPTH):0]   tag_count,
    output logic                         busy,
    output logic                         err_orphan
);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic [TAG_DEPTH-1:0] tag_q;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 prio, locked, lock_g;
    logic                 full, empty, g, t, push, pop;

    always_comb begin
        full       = tag_count == CW'(TAG_DEPTH);
        empty      = tag_count == '0;
        g          = locked ? lock_g : (req0_valid & req1_valid) ? prio : req1_valid;
        acc_valid  = (req0_valid | req1_valid) & ~full;
        acc_data   = g ? req1_data : req0_data;
        req0_ready = acc_ready & ~full & ~g;
        req1_ready = acc_ready & ~full & g;
        t          = tag_q[rd_ptr];
        res_ready  = (t ? out1_ready : out0_ready) & ~empty;
        out0_valid = res_valid & ~empty & ~t;
        out1_valid = res_valid & ~empty & t;
        out0_data  = res_data;
        out1_data  = res_data;
        push       = acc_valid & acc_ready;
        pop        = res_valid & res_ready;
        busy       = ~empty;
    end

    // A stalled issue freezes the grant so acc_data stays stable until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_count  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            prio       <= 1'b0;
            locked     <= 1'b0;
            lock_g     <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr] <= g;
                wr_ptr        <= wr_ptr + AW'(1);
                prio          <= ~g;
                locked        <= 1'b0;
            end else if (acc_valid) begin
                locked <= 1'b1;
                lock_g <= g;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            tag_count  <= tag_count + CW'(push) - CW'(pop);
            err_orphan <= err_orphan | (res_valid & empty);
        end
    end
endmodule

// File: doc/nn_pipe_arbiter.md
NN_PIPE_ARBITER -- requirements
Module: nn_pipe_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of the operand and result data.
REQ-002 The block SHALL have parameter TAG_DEPTH, default 4, giving the maximum number of outstanding pipeline transactions; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid in 1, req0_data in DATA_W and req0_ready out 1: the requester 0 operand handshake.
REQ-006 The block SHALL have ports req1_valid in 1, req1_data in DATA_W and req1_ready out 1: the requester 1 operand handshake.
REQ-007 The block SHALL have ports acc_valid out 1, acc_data out DATA_W and acc_ready in 1: the issue handshake into the accelerator pipeline.
REQ-008 The block SHALL have ports res_valid in 1, res_data in DATA_W and res_ready out 1: the result handshake from the accelerator pipeline.
REQ-009 The block SHALL have ports out0_valid out 1, out0_data out DATA_W and out0_ready in 1: the result delivered to requester 0.
REQ-010 The block SHALL have ports out1_valid out 1, out1_data out DATA_W and out1_ready in 1: the result delivered to requester 1.
REQ-011 The block SHALL have port tag_count, output, $clog2(TAG_DEPTH)+1 bits: the number of outstanding transactions.
REQ-012 The block SHALL have port busy, output, 1 bit: high when tag_count is not 0.
REQ-013 The block SHALL have port err_orphan, output, 1 bit: sticky flag for a result that arrives with no outstanding tag.

Function
REQ-014 Issue SHALL use the grant g, selected as follows:
- If only one requester is valid, g is that requester.
- If both are valid, g is the requester named by the priority pointer prio.
REQ-015 The issue-side outputs SHALL be combinational:
- acc_valid = (req0_valid | req1_valid) & ~full.
- acc_data = reqg_data.
- reqg_ready = acc_ready & ~full.
- The non-granted requester's ready is 0.
REQ-016 While acc_valid=1 and acc_ready=0, the block SHALL register and hold g (lock), so the grant does not change until the issue handshake completes, even if the other requester becomes valid.
REQ-017 On an issue handshake (acc_valid & acc_ready), the block SHALL:
- push g into the tag FIFO;
- set prio to ~g;
- clear the lock.
REQ-018 The full condition SHALL be tag_count==TAG_DEPTH, evaluated on the registered count; a pop in the same cycle SHALL NOT unblock issue.
REQ-019 Return routing SHALL use t, the tag at the FIFO head:
- outt_valid = res_valid & ~empty.
- outt_data = res_data.
- res_ready = outt_ready & ~empty.
- The other out valid is 0.
REQ-020 On a result handshake, the block SHALL pop the tag FIFO; results are delivered strictly in issue order.
REQ-021 With a simultaneous push and pop, tag_count SHALL remain unchanged and the FIFO pointers SHALL advance correctly through wrap-around.
REQ-022 If res_valid=1 while the FIFO is empty, then:
- res_ready SHALL be 0;
- both out valids SHALL be 0;
- err_orphan SHALL be set the next cycle and hold until reset.
REQ-023 The issue and return paths SHALL be independent; issue and result handshakes SHALL be allowed in the same cycle.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL:
- set tag_count to 0;
- set the FIFO pointers to 0;
- set prio to 0 (requester 0 first);
- clear the lock;
- clear err_orphan.
REQ-025 After reset, all valid/ready outputs SHALL follow from the cleared state: acc_valid=0 and res_ready=0 unless the inputs request otherwise, out0_valid=0, out1_valid=0, busy=0.
REQ-026 A reset mid-operation SHALL discard all outstanding tags; results already in the pipeline then take the orphan path after reset.

Verification
REQ-027 Both requesters valid with data 0x11 and 0x22, acc_ready=1 -> issue order 0x11, 0x22, 0x11, 0x22 (alternating), tag_count ramps 1,2,...
REQ-028 Pipeline stall: req1 valid with acc_ready=0 for 3 cycles while req0 rises in cycle 2 -> grant stays on req1; acc_data=req1_data until the handshake.
REQ-029 Issue 4 transactions with no results returned (TAG_DEPTH=4) -> acc_valid=0 and both req ready=0; one pop -> issue resumes the following cycle.
REQ-030 Issue tags 0,1,1 then return results 0xA0, 0xA1, 0xA2 -> 0xA0 appears on out0, 0xA1 and 0xA2 on out1; out1_ready=0 stalls res_ready.
REQ-031 res_valid=1 with tag_count=0 -> res_ready=0 and err_orphan=1 the next cycle, held until reset; reset with 2 tags outstanding -> tag_count=0 and busy=0 the next cycle.
